// File: rtl/hamming_pkg.sv
// Shared definitions for the (22,16) SECDED code: position map, encoder, syndrome
// helper and the write-back FSM state type.
package hamming_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CHK_W  = 6;

  // Codeword position of each data bit d0..d15, five bits per entry, d0 in the LSBs.
  localparam logic [DATA_W*5-1:0] DATA_POS = {
    5'd21, 5'd20, 5'd19, 5'd18, 5'd17, 5'd15, 5'd14, 5'd13,
    5'd12, 5'd11, 5'd10, 5'd9,  5'd7,  5'd6,  5'd5,  5'd3
  };

  typedef enum logic {StRun, StWbReq} wb_state_e;

  function automatic logic [4:0] data_pos(input int unsigned i);
    return DATA_POS[i*5 +: 5];
  endfunction

  // chk[4:0] is the XOR of the positions of all set data bits; chk[5] is overall parity.
  function automatic logic [CHK_W-1:0] hamming_encode(input logic [DATA_W-1:0] data);
    logic [4:0] h;
    h = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (data[i]) h = h ^ data_pos(i);
    end
    return {(^data) ^ (^h), h};
  endfunction

  // Returns {pm, s}: pm is the overall parity mismatch across all 22 received bits.
  function automatic logic [5:0] hamming_syndrome(input logic [DATA_W-1:0] data,
                                                  input logic [CHK_W-1:0]  chk);
    logic [CHK_W-1:0] enc;
    logic [4:0]       s;
    logic             pm;
    enc = hamming_encode(data);
    s   = enc[4:0] ^ chk[4:0];
    pm  = (^data) ^ (^chk);
    return {pm, s};
  endfunction

endpackage

// File: rtl/hamming_corrector.sv
// Combinational SECDED classification and single-bit correction from a precomputed
// syndrome and overall parity mismatch.
module hamming_corrector
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [4:0]        syndrome_i,
  input  logic              pm_i,
  output logic [DATA_W-1:0] data_o,
  output logic              sec_o,
  output logic              ded_o
);

  logic correctable;

  always_comb begin
    correctable = pm_i && (syndrome_i <= 5'd21);
    ded_o       = (!pm_i && (syndrome_i != 5'd0)) || (pm_i && (syndrome_i > 5'd21));
    sec_o       = correctable;
    data_o      = data_i;
    // Syndromes pointing at check-bit positions (or 0) leave the data untouched.
    if (correctable) begin
      for (int unsigned i = 0; i < DATA_W; i++) begin
        if (data_pos(i) == syndrome_i) data_o[i] = ~data_i[i];
      end
    end
  end

endmodule

// File: rtl/hamming_secded_scrubber.sv
// Two-stage SECDED checker that corrects single errors, flags double errors, requests
// a write-back of corrected words and keeps saturating error statistics.
module hamming_secded_scrubber
  import hamming_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned WB_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sec,
  output logic              out_ded,
  output logic [4:0]        out_syndrome,
  output logic              wb_req,
  output logic [DATA_W-1:0] wb_data,
  output logic [CHK_W-1:0]  wb_chk,
  input  logic              wb_ack,
  output logic              wb_timeout,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count
);

  localparam int unsigned TmoW = $clog2(WB_TIMEOUT + 1);

  wb_state_e         state_q, state_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              wb_load;

  logic              xfer;
  logic [5:0]        in_syn;
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [4:0]        s1_syn_q;
  logic              s1_pm_q;

  logic [DATA_W-1:0] corr_data;
  logic              corr_sec, corr_ded;

  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_data_q;
  logic              s2_sec_q, s2_ded_q;
  logic [4:0]        s2_syn_q;

  logic [DATA_W-1:0] wb_data_q;
  logic [CHK_W-1:0]  wb_chk_q;
  logic [CNT_W-1:0]  sec_cnt_q, ded_cnt_q;

  // Stall intake while stage 2 holds a SEC result so the write-back is not overtaken.
  assign in_ready = !rst && (state_q == StRun) && !(s2_valid_q && s2_sec_q);
  assign xfer     = in_valid && in_ready;
  assign in_syn   = hamming_syndrome(in_data, in_chk);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_syn_q   <= '0;
      s1_pm_q    <= 1'b0;
    end else begin
      s1_valid_q <= xfer;
      if (xfer) begin
        s1_data_q <= in_data;
        s1_syn_q  <= in_syn[4:0];
        s1_pm_q   <= in_syn[5];
      end
    end
  end

  hamming_corrector u_corrector (
    .data_i     (s1_data_q),
    .syndrome_i (s1_syn_q),
    .pm_i       (s1_pm_q),
    .data_o     (corr_data),
    .sec_o      (corr_sec),
    .ded_o      (corr_ded)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sec_q   <= 1'b0;
      s2_ded_q   <= 1'b0;
      s2_syn_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_data_q  <= s1_valid_q ? corr_data : '0;
      s2_sec_q   <= s1_valid_q && corr_sec;
      s2_ded_q   <= s1_valid_q && corr_ded;
      s2_syn_q   <= s1_valid_q ? s1_syn_q : '0;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_data     = s2_data_q;
  assign out_sec      = s2_sec_q;
  assign out_ded      = s2_ded_q;
  assign out_syndrome = s2_syn_q;

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    wb_load    = 1'b0;
    wb_timeout = 1'b0;
    unique case (state_q)
      StRun: begin
        tmo_d = '0;
        if (s2_valid_q && s2_sec_q) begin
          state_d = StWbReq;
          wb_load = 1'b1;
        end
      end
      StWbReq: begin
        // Ack takes priority over an expiring timeout in the same cycle.
        if (wb_ack) begin
          state_d = StRun;
          tmo_d   = '0;
        end else if (tmo_q == TmoW'(WB_TIMEOUT - 1)) begin
          state_d    = StRun;
          tmo_d      = '0;
          wb_timeout = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      tmo_q     <= '0;
      wb_data_q <= '0;
      wb_chk_q  <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (wb_load) begin
        wb_data_q <= s2_data_q;
        wb_chk_q  <= hamming_encode(s2_data_q);
      end
    end
  end

  assign wb_req  = (state_q == StWbReq);
  assign wb_data = wb_data_q;
  assign wb_chk  = wb_chk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      if (s2_valid_q && s2_sec_q && (sec_cnt_q != '1)) sec_cnt_q <= sec_cnt_q + 1'b1;
      if (s2_valid_q && s2_ded_q && (ded_cnt_q != '1)) ded_cnt_q <= ded_cnt_q + 1'b1;
    end
  end

  assign sec_count = sec_cnt_q;
  assign ded_count = ded_cnt_q;

endmodule

// File: tb/tb_hamming_secded_scrubber.sv
// Directed self-checking bench for hamming_secded_scrubber with hand-computed codewords.
module tb_hamming_secded_scrubber;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [5:0]  in_chk;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_sec;
  logic        out_ded;
  logic [4:0]  out_syndrome;
  logic        wb_req;
  logic [15:0] wb_data;
  logic [5:0]  wb_chk;
  logic        wb_ack;
  logic        wb_timeout;
  logic [7:0]  sec_count;
  logic [7:0]  ded_count;

  int checks   = 0;
  int failures = 0;

  // Hand-encoded check bits: 0x013A -> 0x2C, 0x0000 -> 0x00, 0xFFFF -> 0x1E.
  localparam logic [5:0] Chk013A = 6'h2C;
  localparam logic [5:0] Chk0000 = 6'h00;
  localparam logic [5:0] ChkFFFF = 6'h1E;

  hamming_secded_scrubber #(
    .CNT_W      (8),
    .WB_TIMEOUT (15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_chk       (in_chk),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_sec      (out_sec),
    .out_ded      (out_ded),
    .out_syndrome (out_syndrome),
    .wb_req       (wb_req),
    .wb_data      (wb_data),
    .wb_chk       (wb_chk),
    .wb_ack       (wb_ack),
    .wb_timeout   (wb_timeout),
    .sec_count    (sec_count),
    .ded_count    (ded_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word; returns in the cycle its result should be on the outputs.
  task automatic send(input logic [15:0] d, input logic [5:0] c);
    check_eq("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_chk   = c;
    tick();
    in_valid = 1'b0;
    check_eq("latency1_no_valid", 32'(out_valid), 32'd0);
    tick();
    check_eq("latency2_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic expect_result(input string tag, input logic [15:0] d, input logic sec,
                               input logic ded, input logic [4:0] syn);
    check_eq({tag, "_data"}, 32'(out_data), 32'(d));
    check_eq({tag, "_sec"}, 32'(out_sec), 32'(sec));
    check_eq({tag, "_ded"}, 32'(out_ded), 32'(ded));
    check_eq({tag, "_syn"}, 32'(out_syndrome), 32'(syn));
  endtask

  initial begin
    int tmo_cycle;
    logic [15:0] clean_d [3];
    logic [5:0]  clean_c [3];
    clean_d = '{16'h0000, 16'h013A, 16'hFFFF};
    clean_c = '{Chk0000, Chk013A, ChkFFFF};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_chk   = '0;
    wb_ack   = 1'b0;
    tick();
    tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_wb_req", 32'(wb_req), 32'd0);
    check_eq("rst_wb_data", 32'(wb_data), 32'd0);
    check_eq("rst_sec_count", 32'(sec_count), 32'd0);
    check_eq("rst_ded_count", 32'(ded_count), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Clean words pass through untouched.
    for (int i = 0; i < 3; i++) begin
      send(clean_d[i], clean_c[i]);
      expect_result("clean", clean_d[i], 1'b0, 1'b0, 5'd0);
      tick();
      check_eq("clean_no_wb_req", 32'(wb_req), 32'd0);
    end

    // d3 (position 7) flipped: corrected, write-back acked in the third WB_REQ cycle.
    send(16'h0132, Chk013A);
    expect_result("sec_d3", 16'h013A, 1'b1, 1'b0, 5'd7);
    check_eq("sec_d3_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    check_eq("sec_d3_wb_req", 32'(wb_req), 32'd1);
    check_eq("sec_d3_wb_data", 32'(wb_data), 32'h013A);
    check_eq("sec_d3_wb_chk", 32'(wb_chk), 32'(Chk013A));
    tick();
    tick();
    check_eq("sec_d3_wb_data_stable", 32'(wb_data), 32'h013A);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    check_eq("sec_d3_back_run", 32'(wb_req), 32'd0);
    check_eq("sec_d3_in_ready", 32'(in_ready), 32'd1);
    check_eq("sec_d3_count", 32'(sec_count), 32'd1);

    // Overall parity bit flipped: data unchanged, syndrome 0, still a write-back.
    send(16'h013A, Chk013A ^ 6'h20);
    expect_result("sec_p", 16'h013A, 1'b1, 1'b0, 5'd0);
    tick();
    check_eq("sec_p_wb_req", 32'(wb_req), 32'd1);
    check_eq("sec_p_wb_chk", 32'(wb_chk), 32'(Chk013A));
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    check_eq("sec_p_count", 32'(sec_count), 32'd2);

    // d0 and d1 flipped: double error, syndrome 3^5=6, no write-back.
    send(16'h0139, Chk013A);
    expect_result("ded", 16'h0139, 1'b0, 1'b1, 5'd6);
    tick();
    check_eq("ded_no_wb_req", 32'(wb_req), 32'd0);
    check_eq("ded_count", 32'(ded_count), 32'd1);

    // No ack: timeout pulses in the 15th WB_REQ cycle.
    send(16'h0132, Chk013A);
    tick();
    tmo_cycle = 0;
    for (int n = 1; n <= 20; n++) begin
      if (wb_timeout) begin
        tmo_cycle = n;
        break;
      end
      tick();
    end
    check_eq("timeout_cycle", 32'(tmo_cycle), 32'd15);
    tick();
    check_eq("timeout_wb_req_low", 32'(wb_req), 32'd0);
    check_eq("timeout_in_ready", 32'(in_ready), 32'd1);

    // Ack arriving on the expiry cycle suppresses the timeout pulse.
    send(16'h0132, Chk013A);
    tick();
    for (int n = 1; n < 15; n++) tick();
    wb_ack = 1'b1;
    #1;
    check_eq("ack_wins_no_timeout", 32'(wb_timeout), 32'd0);
    tick();
    wb_ack = 1'b0;
    check_eq("ack_wins_run", 32'(wb_req), 32'd0);
    check_eq("sec_count_4", 32'(sec_count), 32'd4);

    // 300 corrected words with immediate ack saturate sec_count.
    wb_ack = 1'b1;
    for (int n = 0; n < 300; n++) begin
      send(16'h0132, Chk013A);
      tick();
      tick();
    end
    wb_ack = 1'b0;
    check_eq("sec_count_sat", 32'(sec_count), 32'd255);

    // Reset in the middle of a write-back.
    send(16'h0132, Chk013A);
    tick();
    check_eq("mid_wb_req", 32'(wb_req), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    check_eq("mid_rst_wb_req", 32'(wb_req), 32'd0);
    check_eq("mid_rst_sec_count", 32'(sec_count), 32'd0);
    check_eq("mid_rst_ded_count", 32'(ded_count), 32'd0);

    // Reset with a word in stage 1: it never emerges.
    in_valid = 1'b1;
    in_data  = 16'h013A;
    in_chk   = Chk013A;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("flush_no_valid_0", 32'(out_valid), 32'd0);
    tick();
    check_eq("flush_no_valid_1", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_secded_scrubber.md
Name: hamming_secded_scrubber

Overview:
- Downstream checker/scrubber for the Hamming-protected 16-bit counter.
- Consumes each sampled counter word plus its stored check bits, then:
  - computes the syndrome over a 2-stage pipeline,
  - corrects single-bit errors and flags double-bit errors,
  - requests a write-back of the corrected word to the counter stage over a req/ack handshake.
- Keeps saturating error statistics for observability.

Parameters:
- DATA_W, 16, protected data width; only 16 is supported (fixed (22,16) SECDED code).
- CHK_W, 6, check bits: 5 Hamming bits plus 1 overall parity.
- CNT_W, 8, width of each saturating error counter.
- WB_TIMEOUT, 15, cycles to wait for wb_ack before abandoning a write-back.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  16  counter value as stored.
- in_chk  in  6  stored check bits: [4:0] Hamming, [5] overall parity.
- out_valid  out  1  one-cycle pulse, result valid.
- out_data  out  16  corrected data.
- out_sec  out  1  single error corrected (includes an error in check bits only).
- out_ded  out  1  uncorrectable error detected.
- out_syndrome  out  5  raw syndrome of the result.
- wb_req  out  1  write-back request to the counter stage.
- wb_data  out  16  corrected word to reload.
- wb_chk  out  6  recomputed check bits for wb_data.
- wb_ack  in  1  counter stage accepted the write-back.
- wb_timeout  out  1  one-cycle pulse when a write-back is abandoned.
- sec_count  out  CNT_W  saturating count of corrected errors.
- ded_count  out  CNT_W  saturating count of uncorrectable errors.

Behaviour:
- Code layout:
  - Codeword positions 1..21. Check bits sit at positions 1, 2, 4, 8, 16.
  - d0..d15 map in order to 3,5,6,7,9,10,11,12,13,14,15,17,18,19,20,21.
  - Overall parity is the XOR of all 21 positions.
- Handshake: a transfer occurs when in_valid && in_ready.
- Stage 1 (registered): data, syndrome s[4:0] = recomputed XOR stored Hamming bits, overall mismatch pm.
- Stage 2 (registered): classification and correction.
- Latency: out_valid fires exactly 2 cycles after the transfer; there is no output backpressure.
- Classification:
  - s=0, pm=0: clean; out_sec=0, out_ded=0.
  - pm=1, s in 1..21: flip position s; if s is a data position the data bit is corrected; out_sec=1.
  - pm=1, s=0: the overall parity bit itself failed; data unchanged; out_sec=1.
  - pm=0, s≠0: double error; data passed uncorrected; out_ded=1.
  - pm=1, s in 22..31: out_ded=1.
- FSM states: RUN, WB_REQ.
- RUN: in_ready=1. On a stage-2 result with out_sec=1 → WB_REQ.
  - The stage-2 result is the only write-back trigger.
  - A word already in stage 1 completes normally.
  - in_ready drops on the cycle stage 2 holds a SEC result.
- WB_REQ: in_ready=0; wb_req=1; wb_data/wb_chk held stable.
  - wb_ack=1 → RUN on the next cycle.
  - WB_TIMEOUT cycles without ack → pulse wb_timeout, return to RUN.
  - A SEC result from the stage-1 word that completes during WB_REQ raises no second write-back; it is only counted.
- DED never triggers a write-back.
- Counters increment on out_valid && out_sec (sec_count) or out_valid && out_ded (ded_count) and hold at 2^CNT_W-1.
- Reset values: in_ready=0 during rst and 1 the cycle after. All other outputs are 0, pipeline valids are cleared, FSM=RUN.
- Reset mid-operation: in-flight words and any pending write-back are discarded with no out_valid.
- Simultaneous wb_ack and timeout expiry: ack wins, no wb_timeout pulse.

Decomposition:
- Package hamming_pkg holds:
  - DATA_W, CHK_W,
  - the position map,
  - functions hamming_encode(data) → chk[5:0] and hamming_syndrome(data, chk) → {pm, s},
  - the state enum {RUN, WB_REQ}.
- One sub-module is natural: hamming_corrector, the combinational stage-2 classify/flip logic, reused by the counter stage's self-check.

Test Plan:
- Clean words 16'h0000, 16'h013A, 16'hFFFF with their encoded chk → out_valid 2 cycles later, out_data equals input, sec=0, ded=0, no wb_req.
- 16'h013A with d3 flipped (in_data 16'h0132), good chk → out_data 16'h013A, syndrome 7, out_sec=1, wb_req with wb_data 16'h013A and wb_chk = encode(16'h013A); ack after 3 cycles → back to RUN, sec_count=1.
- 16'h013A with chk[5] flipped → out_data 16'h013A, syndrome 0, out_sec=1, write-back issued.
- 16'h013A with d0 and d1 flipped → out_ded=1, out_data 16'h0139 uncorrected, no wb_req, ded_count=1.
- SEC word with wb_ack tied 0 → wb_timeout pulses on cycle 15 of WB_REQ, in_ready returns to 1.
- 300 consecutive SEC words with immediate ack → sec_count saturates at 255; rst asserted mid-WB_REQ → wb_req=0 the next cycle, counters cleared to 0.
